acce_stream_ctrl: RTL and testbench

ACCE_STREAM_CTRL -- requirements
Module: acce_stream_ctrl

---
 rtl/acce_pkg.sv | 14 +
 rtl/acce_res_fifo.sv | 56 +++++
 rtl/acce_stream_ctrl.sv | 132 +++++++++++++
 tb/tb_acce_stream_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/acce_pkg.sv
// Shared definitions for the accelerator stream controller slice.
package acce_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_F,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/acce_res_fifo.sv
// Result FIFO between accelerator output and memory sink; reports free entries
// and flags words dropped on overflow.
module acce_res_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_W     = acce_pkg::DATA_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_push,
    input  logic [DATA_W-1:0]             i_push_data,
    input  logic                          i_pop,
    output logic [DATA_W-1:0]             o_pop_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_free,
    output logic                          o_drop
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [AW:0]       w_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign o_full     = (w_count == (AW+1)'(FIFO_DEPTH));
    assign o_empty    = (w_count == '0);
    assign o_free     = (AW+1)'(FIFO_DEPTH) - w_count;
    assign w_do_pop   = i_pop && !o_empty;
    // When full, a same-cycle pop frees the slot the push lands in.
    assign w_do_push  = i_push && (!o_full || w_do_pop);
    assign o_drop     = i_push && o_full && !w_do_pop;
    assign o_pop_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    // NOTE: the storage array has no reset; emptiness is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        end
    end

    // NOTE: this codebase's reset is active-high despite its name, hence posedge rst_n.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/acce_stream_ctrl.sv
// Layer-job controller: streams weights then features into the accelerator and
// drains its results through a FIFO to the memory sink.
module acce_stream_ctrl
    import acce_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  w_words,
    input  logic [CNT_W-1:0]  f_words,
    input  logic [CNT_W-1:0]  o_words,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [DATA_W-1:0] src_data,
    input  logic              src_valid,
    output logic              src_ready,
    output logic [DATA_W-1:0] acc_data,
    output logic              acc_valid,
    output logic              acc_bus_free,
    input  logic              acc_weight_ing,
    input  logic [DATA_W-1:0] acc_res_data,
    input  logic              acc_res_valid,
    input  logic              acc_conv_done,
    output logic [DATA_W-1:0] snk_data,
    output logic              snk_valid,
    input  logic              snk_ready
);

    localparam int FW = $clog2(FIFO_DEPTH) + 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_w_words, r_f_words, r_o_words;
    logic [CNT_W-1:0] r_w_cnt, r_f_cnt, r_out_cnt;
    logic [CNT_W-1:0] w_out_cnt_nxt;
    logic             r_conv_seen, r_err;
    logic             w_idle, w_loading, w_start_ok, w_start_bad;
    logic             w_push, w_pop, w_drop, w_full, w_empty;
    logic [FW-1:0]    w_free;
    logic             w_conv_seen_nxt, w_w_last, w_f_last, w_err_evt;

    assign w_idle      = (r_state == IDLE);
    assign w_loading   = (r_state == LOAD_W) || (r_state == LOAD_F);
    assign w_start_ok  = w_idle && start && (w_words != '0) && (o_words != '0);
    assign w_start_bad = w_idle && start && ((w_words == '0) || (o_words == '0));

    assign busy      = !w_idle;
    assign done      = (r_state == DONE);
    assign err       = r_err;
    assign src_ready = (r_state == LOAD_W) || ((r_state == LOAD_F) && !acc_weight_ing);
    assign acc_valid = src_valid && src_ready;
    assign acc_data  = w_loading ? src_data : '0;

    assign w_push       = acc_res_valid && !w_idle;
    assign snk_valid    = !w_empty;
    assign w_pop        = snk_valid && snk_ready;
    // Two free slots cover a result already in flight when bus_free drops.
    assign acc_bus_free = !w_idle && (w_free >= FW'(2));

    assign w_out_cnt_nxt   = (w_pop && (r_out_cnt != '1)) ? r_out_cnt + 1'b1 : r_out_cnt;
    assign w_conv_seen_nxt = r_conv_seen || (acc_conv_done && (w_loading || (r_state == RUN)));
    assign w_w_last        = ((r_w_cnt + 1'b1) == r_w_words);
    assign w_f_last        = ((r_f_cnt + 1'b1) == r_f_words);
    assign w_err_evt       = (acc_res_valid && w_idle) || w_drop
                           || (w_pop && (r_out_cnt >= r_o_words));

    acce_res_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (DATA_W)
    ) u_res_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (acc_res_data),
        .i_pop       (w_pop),
        .o_pop_data  (snk_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_free      (w_free),
        .o_drop      (w_drop)
    );

    // NOTE: next state defaults to the current state so no path leaves it unassigned.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:   if (w_start_ok) w_state_nxt = LOAD_W;
            LOAD_W: if (acc_valid && w_w_last) w_state_nxt = (r_f_words == '0) ? RUN : LOAD_F;
            LOAD_F: if (acc_valid && w_f_last) w_state_nxt = RUN;
            RUN:    if (w_conv_seen_nxt && (w_out_cnt_nxt == r_o_words)) w_state_nxt = DONE;
            DONE:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state     <= IDLE;
            r_w_words   <= '0;
            r_f_words   <= '0;
            r_o_words   <= '0;
            r_w_cnt     <= '0;
            r_f_cnt     <= '0;
            r_out_cnt   <= '0;
            r_conv_seen <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_ok) begin
                r_w_words   <= w_words;
                r_f_words   <= f_words;
                r_o_words   <= o_words;
                r_w_cnt     <= '0;
                r_f_cnt     <= '0;
                r_out_cnt   <= '0;
                r_conv_seen <= 1'b0;
                r_err       <= 1'b0;
            end else begin
                if (acc_valid && (r_state == LOAD_W)) r_w_cnt <= r_w_cnt + 1'b1;
                if (acc_valid && (r_state == LOAD_F)) r_f_cnt <= r_f_cnt + 1'b1;
                r_out_cnt   <= w_out_cnt_nxt;
                r_conv_seen <= w_conv_seen_nxt;
                r_err       <= r_err | w_start_bad | w_err_evt;
            end
        end
    end

endmodule

// File: tb/tb_acce_stream_ctrl.sv
// Directed bench for acce_stream_ctrl with scoreboard queues on the accelerator
// input stream and the result sink stream.
module tb_acce_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] w_words, f_words, o_words;
    logic        busy, done, err;
    logic [31:0] src_data;
    logic        src_valid, src_ready;
    logic [31:0] acc_data;
    logic        acc_valid, acc_bus_free;
    logic        acc_weight_ing;
    logic [31:0] acc_res_data;
    logic        acc_res_valid, acc_conv_done;
    logic [31:0] snk_data;
    logic        snk_valid, snk_ready;

    int          n_tests  = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    int          d0;
    logic [31:0] exp_acc [$];
    logic [31:0] exp_snk [$];

    always #5 clk = ~clk;

    acce_stream_ctrl #(.FIFO_DEPTH(8), .CNT_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .w_words        (w_words),
        .f_words        (f_words),
        .o_words        (o_words),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .src_data       (src_data),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .acc_data       (acc_data),
        .acc_valid      (acc_valid),
        .acc_bus_free   (acc_bus_free),
        .acc_weight_ing (acc_weight_ing),
        .acc_res_data   (acc_res_data),
        .acc_res_valid  (acc_res_valid),
        .acc_conv_done  (acc_conv_done),
        .snk_data       (snk_data),
        .snk_valid      (snk_valid),
        .snk_ready      (snk_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every accelerator beat and every sink pop is matched in order.
    always @(negedge clk) begin
        if (!rst_n) begin
            if (done) done_cnt++;
            if (acc_valid) begin
                check("acc_beat_expected", 32'(exp_acc.size() != 0), 1);
                if (exp_acc.size() != 0) check("acc_data", acc_data, exp_acc.pop_front());
            end
            if (snk_valid && snk_ready) begin
                check("snk_pop_expected", 32'(exp_snk.size() != 0), 1);
                if (exp_snk.size() != 0) check("snk_data", snk_data, exp_snk.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] w, input logic [15:0] f, input logic [15:0] o);
        w_words = w; f_words = f; o_words = o; start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send_words(input int n, input int w_split, input int wi_cycles, input logic [31:0] base);
        int k;
        for (int i = 0; i < n; i++) begin
            src_data  = base + 32'(i);
            src_valid = 1'b1;
            exp_acc.push_back(base + 32'(i));
            if (i == w_split && wi_cycles > 0) begin
                acc_weight_ing = 1'b1;
                for (int c = 0; c < wi_cycles; c++) begin
                    @(negedge clk);
                    check("src_ready_while_weight_ing", 32'(src_ready), 0);
                    tick(1);
                end
                acc_weight_ing = 1'b0;
            end
            for (k = 0; k < 50; k++) begin
                @(negedge clk);
                if (src_ready) break;
            end
            check("src_handshake_in_time", 32'(k < 50), 1);
            tick(1);
        end
        src_valid = 1'b0;
    endtask

    task automatic send_result(input logic [31:0] d, input bit expect_out);
        acc_res_data  = d;
        acc_res_valid = 1'b1;
        if (expect_out) exp_snk.push_back(d);
        tick(1);
        acc_res_valid = 1'b0;
        acc_res_data  = '0;
    endtask

    task automatic pulse_conv();
        acc_conv_done = 1'b1;
        tick(1);
        acc_conv_done = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_src_ready"}, 32'(src_ready), 0);
        check({tag, "_acc_valid"}, 32'(acc_valid), 0);
        check({tag, "_acc_bus_free"}, 32'(acc_bus_free), 0);
        check({tag, "_snk_valid"}, 32'(snk_valid), 0);
        check({tag, "_acc_data"}, acc_data, 0);
        check({tag, "_snk_data"}, snk_data, 0);
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; w_words = '0; f_words = '0; o_words = '0;
        src_data = 32'hFFFF_FFFF; src_valid = 1'b1; acc_weight_ing = 1'b0;
        acc_res_data = '0; acc_res_valid = 1'b0; acc_conv_done = 1'b0; snk_ready = 1'b1;
        #1;
        check_quiet("reset");
        tick(2);
        src_valid = 1'b0; src_data = '0;
        rst_n = 1'b0;
        tick(1);

        // Basic job: 4 weights, 6 features, 3 results.
        d0 = done_cnt;
        do_start(4, 6, 3);
        check("job1_busy", 32'(busy), 1);
        send_words(10, 4, 0, 32'hA000_0000);
        check("job1_acc_all_sent", 32'(exp_acc.size()), 0);
        for (int i = 0; i < 3; i++) send_result(32'hA100_0000 + 32'(i), 1'b1);
        tick(3);
        check("job1_snk_drained", 32'(exp_snk.size()), 0);
        check("job1_no_done_before_conv", 32'(done_cnt - d0), 0);
        do_start(0, 0, 0);
        check("start_ignored_err", 32'(err), 0);
        check("start_ignored_busy", 32'(busy), 1);
        pulse_conv();
        tick(3);
        check("job1_done_once", 32'(done_cnt - d0), 1);
        check("job1_idle", 32'(busy), 0);

        // Rejected start.
        d0 = done_cnt;
        do_start(0, 5, 5);
        check("bad_start_err", 32'(err), 1);
        check("bad_start_busy", 32'(busy), 0);
        tick(1);
        check("bad_start_no_done", 32'(done_cnt - d0), 0);

        // Weight absorption stalls the feature stream.
        d0 = done_cnt;
        do_start(2, 3, 1);
        check("good_start_clears_err", 32'(err), 0);
        send_words(5, 2, 5, 32'hB000_0000);
        send_result(32'hB100_0000, 1'b1);
        pulse_conv();
        tick(3);
        check("job2_done_once", 32'(done_cnt - d0), 1);
        check("job2_acc_all_sent", 32'(exp_acc.size()), 0);

        // Overflow: sink stalled, accelerator ignores bus_free, nine results.
        d0 = done_cnt;
        snk_ready = 1'b0;
        do_start(1, 0, 8);
        send_words(1, 1, 0, 32'hC000_0000);
        for (int k = 0; k < 9; k++) begin
            send_result(32'hC100_0000 + 32'(k), k < 8);
            check($sformatf("ovf_bus_free_%0d", k), 32'(acc_bus_free), 32'((k + 1) <= 6));
            check($sformatf("ovf_err_%0d", k), 32'(err), 32'(k == 8));
        end
        snk_ready = 1'b1;
        pulse_conv();
        tick(12);
        check("job3_done_once", 32'(done_cnt - d0), 1);
        check("job3_snk_drained", 32'(exp_snk.size()), 0);
        check("job3_err_sticky", 32'(err), 1);

        // Last pop coincides with conv_done.
        d0 = done_cnt;
        do_start(1, 0, 2);
        check("job4_err_cleared", 32'(err), 0);
        send_words(1, 1, 0, 32'hD000_0000);
        send_result(32'hD100_0000, 1'b1);
        tick(1);
        send_result(32'hD100_0001, 1'b1);
        acc_conv_done = 1'b1;
        @(negedge clk);
        check("job4_done_early", 32'(done), 0);
        check("job4_last_pop_pending", 32'(snk_valid), 1);
        tick(1);
        acc_conv_done = 1'b0;
        @(negedge clk);
        check("job4_done_pulse", 32'(done), 1);
        tick(1);
        @(negedge clk);
        check("job4_done_one_cycle", 32'(done), 0);
        check("job4_idle", 32'(busy), 0);
        tick(1);
        check("job4_done_count", 32'(done_cnt - d0), 1);

        // Reset in LOAD_F abandons the job.
        d0 = done_cnt;
        do_start(2, 3, 1);
        send_words(3, 2, 0, 32'hE000_0000);
        src_data = 32'h1234_5678; src_valid = 1'b1;
        rst_n = 1'b1;
        #1;
        check_quiet("midjob_reset");
        exp_acc.delete();
        exp_snk.delete();
        tick(2);
        src_valid = 1'b0; src_data = '0;
        rst_n = 1'b0;
        tick(3);
        check("midjob_reset_no_done", 32'(done_cnt - d0), 0);
        do_start(1, 1, 1);
        send_words(2, 1, 0, 32'hF000_0000);
        send_result(32'hF100_0000, 1'b1);
        pulse_conv();
        tick(3);
        check("after_reset_done", 32'(done_cnt - d0), 1);
        check("after_reset_err", 32'(err), 0);

        check("final_acc_queue_empty", 32'(exp_acc.size()), 0);
        check("final_snk_queue_empty", 32'(exp_snk.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
